// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the external PC register, issues one imem fetch at a time
// and hands words to decode. Define FETCH_SEQ_MISALIGN_TRAP_EN to trap on misaligned redirects.
module fetch_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] TRAP_VECTOR  = 64'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_q,
    output logic [63:0] pc_d,
    output logic        pc_en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic        imem_rsp_err,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        trap,
    output logic        trap_cause
);

    typedef enum logic [2:0] {StBoot, StReq, StWait, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] hold_data_q;
    logic [63:0] hold_pc_q;
    logic        hold_load;
    logic [63:0] redir_pc;
    logic        redir_trap;
    logic [63:0] pc_inc;
    logic        unused_target_lsbs;

    assign imem_req_addr      = pc_q;
    assign pc_inc             = pc_q + 64'd4;
    assign unused_target_lsbs = ^redirect_target[1:0];

    always_comb begin
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
        redir_trap = (redirect_target[1:0] != 2'b00);
        redir_pc   = redir_trap ? TRAP_VECTOR : redirect_target;
`else
        redir_trap = 1'b0;
        redir_pc   = {redirect_target[63:2], 2'b00};
`endif
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pc_en          = 1'b0;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        inst_data      = 32'h0;
        inst_pc        = 64'h0;
        trap           = 1'b0;
        trap_cause     = 1'b0;
        hold_load      = 1'b0;

        unique case (state_q)
            StBoot: begin
                pc_d    = RESET_VECTOR;
                pc_en   = 1'b1;
                state_d = StReq;
            end
            StReq: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_d = StWait;
                // An accepted request under redirect fetches the old PC and must be drained
                if (redirect_valid) state_d = imem_req_ready ? StDrain : StReq;
            end
            StWait: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? StReq : StDrain;
                end else if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        trap    = 1'b1;
                        pc_d    = TRAP_VECTOR;
                        pc_en   = 1'b1;
                        state_d = StReq;
                    end else begin
                        inst_valid = 1'b1;
                        inst_data  = imem_rsp_data;
                        inst_pc    = pc_q;
                        if (inst_ready) begin
                            pc_d    = pc_inc;
                            pc_en   = 1'b1;
                            state_d = StReq;
                        end else begin
                            hold_load = 1'b1;
                            state_d   = StHold;
                        end
                    end
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    state_d = StReq;
                end else begin
                    inst_valid = 1'b1;
                    inst_data  = hold_data_q;
                    inst_pc    = hold_pc_q;
                    if (inst_ready) begin
                        pc_d    = pc_inc;
                        pc_en   = 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StDrain: begin
                // Stale response is dropped, error or not; a redirect here keeps waiting for it
                if (imem_rsp_valid) state_d = StReq;
            end
            default: state_d = StBoot;
        endcase

        if (redirect_valid && (state_q != StBoot)) begin
            pc_d       = redir_pc;
            pc_en      = 1'b1;
            trap       = redir_trap;
            trap_cause = redir_trap;
        end

        if (reset) begin
            state_d        = StBoot;
            pc_d           = RESET_VECTOR;
            pc_en          = 1'b0;
            imem_req_valid = 1'b0;
            inst_valid     = 1'b0;
            inst_data      = 32'h0;
            inst_pc        = 64'h0;
            trap           = 1'b0;
            trap_cause     = 1'b0;
            hold_load      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StBoot;
            hold_data_q <= 32'h0;
            hold_pc_q   <= 64'h0;
        end else begin
            state_q <= state_d;
            if (hold_load) begin
                hold_data_q <= imem_rsp_data;
                hold_pc_q   <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a transaction-level fetch model predicts requests,
// delivered instructions and per-cycle control; a negedge monitor compares.
module tb_fetch_sequencer;

    localparam logic [63:0] RESET_VEC = 64'h0;
    localparam logic [63:0] TRAP_VEC  = 64'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc_q = 64'h0;
    logic [63:0] pc_d;
    logic        pc_en;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic        imem_rsp_err = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = 64'h0;
    logic        trap;
    logic        trap_cause;

    fetch_sequencer #(
        .RESET_VECTOR(RESET_VEC),
        .TRAP_VECTOR (TRAP_VEC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_q           (pc_q),
        .pc_d           (pc_d),
        .pc_en          (pc_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_err   (imem_rsp_err),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap           (trap),
        .trap_cause     (trap_cause)
    );

    initial forever #5 clk = ~clk;

    // External PC register
    always_ff @(posedge clk) if (pc_en) pc_q <= pc_d;

    typedef struct packed {
        logic        req_valid;
        logic        inst_valid;
        logic        pc_en;
        logic        trap;
        logic        cause;
        logic [63:0] pc_d;
    } cyc_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] data;
    } inst_t;

    cyc_t        cyc_q[$];
    logic [63:0] req_q[$];
    inst_t       inst_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          done = 1'b0;

    // Fetch model: architectural next-fetch PC plus the single in-flight / held transaction
    bit          m_boot = 1'b1;
    logic [63:0] arch_pc = 64'h0;
    bit          out_busy = 1'b0;
    bit          out_stale = 1'b0;
    bit          out_err = 1'b0;
    logic [63:0] out_addr = 64'h0;
    int          out_wait = 0;
    bit          pend = 1'b0;
    logic [63:0] pend_pc = 64'h0;
    int          next_delay = 0;
    bit          next_err = 1'b0;
    bit          late_rsp = 1'b0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic void redirect_effect(input logic [63:0] t, output logic [63:0] npc,
                                            output bit tr);
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
        tr  = (t[1:0] != 2'b00);
        npc = tr ? TRAP_VEC : t;
`else
        tr  = 1'b0;
        npc = t & ~64'h3;
`endif
    endfunction

    // Drive one cycle of inputs (called at posedge+1) and push what the model predicts.
    task automatic drive_cycle(input bit rv, input logic [63:0] rt, input bit ir, input bit rdy);
        cyc_t        e;
        inst_t       it;
        bit          rsp, can_req, rtrap;
        logic [63:0] npc;
        rsp             = out_busy && (out_wait == 0);
        redirect_valid  = rv;
        redirect_target = rt;
        inst_ready      = ir;
        imem_req_ready  = rdy;
        imem_rsp_valid  = rsp || (m_boot && late_rsp);
        imem_rsp_err    = rsp ? out_err : 1'($urandom_range(0, 1));
        imem_rsp_data   = rsp ? mem_word(out_addr) : $urandom();
        e = '0;
        if (m_boot) begin
            e.pc_en  = 1'b1;
            e.pc_d   = RESET_VEC;
            arch_pc  = RESET_VEC;
            m_boot   = 1'b0;
            late_rsp = 1'b0;
        end else begin
            can_req     = !out_busy && !pend;
            e.req_valid = can_req;
            redirect_effect(rt, npc, rtrap);
            if (rsp) begin
                out_busy = 1'b0;
                if (!(out_stale || rv)) begin
                    if (out_err) begin
                        e.trap  = 1'b1;
                        e.pc_en = 1'b1;
                        e.pc_d  = TRAP_VEC;
                        arch_pc = TRAP_VEC;
                    end else begin
                        e.inst_valid = 1'b1;
                        it.pc   = out_addr;
                        it.data = mem_word(out_addr);
                        inst_q.push_back(it);
                        if (ir) begin
                            e.pc_en = 1'b1;
                            e.pc_d  = out_addr + 64'd4;
                            arch_pc = out_addr + 64'd4;
                        end else begin
                            pend    = 1'b1;
                            pend_pc = out_addr;
                        end
                    end
                end
            end else if (out_busy) begin
                if (rv) out_stale = 1'b1;
                out_wait--;
            end else if (pend) begin
                if (rv) begin
                    pend = 1'b0;
                    if (inst_q.size() > 0) void'(inst_q.pop_back());
                end else begin
                    e.inst_valid = 1'b1;
                    if (ir) begin
                        pend    = 1'b0;
                        e.pc_en = 1'b1;
                        e.pc_d  = pend_pc + 64'd4;
                        arch_pc = pend_pc + 64'd4;
                    end
                end
            end
            if (can_req && rdy) begin
                req_q.push_back(arch_pc);
                out_busy  = 1'b1;
                out_addr  = arch_pc;
                out_stale = rv;
                out_wait  = next_delay;
                out_err   = next_err;
            end
            if (rv) begin
                e.pc_en      = 1'b1;
                e.pc_d       = npc;
                e.inst_valid = 1'b0;
                e.trap       = rtrap;
                e.cause      = rtrap;
                arch_pc      = npc;
            end
        end
        cyc_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input bit late);
        late_rsp        = late && out_busy;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        inst_ready      = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        if (pend && inst_q.size() > 0) void'(inst_q.pop_back());
        out_busy = 1'b0;
        pend     = 1'b0;
        m_boot   = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Let any in-flight or held transaction finish so the DUT idles in its request state
    task automatic settle();
        for (int i = 0; i < 20 && (out_busy || pend || m_boot); i++) drive_cycle(0, 64'h0, 1, 0);
    endtask

    initial begin
        do_reset(3, 0);
        next_delay = 0;
        next_err   = 0;
        repeat (6) drive_cycle(0, 64'h0, 1, 1);
        repeat (3) drive_cycle(0, 64'h0, 0, 1);
        drive_cycle(0, 64'h0, 1, 1);
        next_delay = 2;
        drive_cycle(0, 64'h0, 1, 1);
        next_delay = 0;
        drive_cycle(1, 64'h200, 1, 1);
        repeat (6) drive_cycle(0, 64'h0, 1, 1);
        settle();
        drive_cycle(1, 64'h40, 1, 0);
        next_err = 1;
        drive_cycle(0, 64'h0, 1, 1);
        next_err = 0;
        repeat (4) drive_cycle(0, 64'h0, 1, 1);
        settle();
        next_err = 1;
        drive_cycle(0, 64'h0, 1, 1);
        next_err = 0;
        drive_cycle(1, 64'h300, 1, 1);
        repeat (3) drive_cycle(0, 64'h0, 1, 1);
        settle();
        drive_cycle(1, 64'h202, 1, 0);
        repeat (3) drive_cycle(0, 64'h0, 1, 1);
        settle();
        drive_cycle(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
        repeat (4) drive_cycle(0, 64'h0, 1, 1);
        settle();
        drive_cycle(0, 64'h0, 1, 1);
        do_reset(2, 1);
        repeat (4) drive_cycle(0, 64'h0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            next_delay = $urandom_range(0, 3);
            next_err   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2), 1'($urandom_range(0, 1)));
            drive_cycle(($urandom_range(0, 9) == 0), {$urandom(), $urandom()},
                        ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
        end
        next_err = 0;
        repeat (10) drive_cycle(0, 64'h0, 1, 0);
        done = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        cyc_t        e;
        inst_t       it;
        logic [63:0] ra;
        forever begin
            @(negedge clk);
            if (done) begin
                n_checks++;
                if (cyc_q.size() != 0 || req_q.size() != 0 || inst_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL leftover_expectations got cyc=%0d req=%0d inst=%0d exp 0 0 0",
                             cyc_q.size(), req_q.size(), inst_q.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
                $finish;
            end else if (reset) begin
                n_checks++;
                if (imem_req_valid || inst_valid || trap || pc_en || pc_d != RESET_VEC ||
                    inst_data != 32'h0 || inst_pc != 64'h0) begin
                    n_fail++;
                    $display("FAIL reset_outputs got req=%0b inst=%0b trap=%0b pc_en=%0b pc_d=%h data=%h pc=%h exp zeros pc_d=%h",
                             imem_req_valid, inst_valid, trap, pc_en, pc_d, inst_data, inst_pc,
                             RESET_VEC);
                end
            end else begin
                n_checks++;
                if (cyc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cycle_underflow got no expectation for t=%0t", $time);
                end else begin
                    e = cyc_q.pop_front();
                    if ({imem_req_valid, inst_valid, pc_en, trap} !==
                        {e.req_valid, e.inst_valid, e.pc_en, e.trap} ||
                        (e.pc_en && pc_d !== e.pc_d) || (e.trap && trap_cause !== e.cause)) begin
                        n_fail++;
                        $display("FAIL cycle_ctrl t=%0t got req=%0b iv=%0b en=%0b trap=%0b cause=%0b pc_d=%h exp req=%0b iv=%0b en=%0b trap=%0b cause=%0b pc_d=%h",
                                 $time, imem_req_valid, inst_valid, pc_en, trap, trap_cause, pc_d,
                                 e.req_valid, e.inst_valid, e.pc_en, e.trap, e.cause, e.pc_d);
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    n_checks++;
                    if (req_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL req_unexpected got addr=%h exp no request", imem_req_addr);
                    end else begin
                        ra = req_q.pop_front();
                        if (imem_req_addr !== ra) begin
                            n_fail++;
                            $display("FAIL req_addr got=%h exp=%h", imem_req_addr, ra);
                        end
                    end
                end
                if (inst_valid && inst_ready) begin
                    n_checks++;
                    if (inst_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL inst_unexpected got pc=%h data=%h exp none", inst_pc, inst_data);
                    end else begin
                        it = inst_q.pop_front();
                        if (inst_pc !== it.pc || inst_data !== it.data) begin
                            n_fail++;
                            $display("FAIL inst_word got pc=%h data=%h exp pc=%h data=%h",
                                     inst_pc, inst_data, it.pc, it.data);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 64'h0, SHALL be the first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 64'h100, SHALL be the PC load value on any trap.
REQ-003 clk  input  1  SHALL be the clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 pc_q  input  64  SHALL be the current value of the external PC register.
REQ-006 pc_d  output  64  SHALL be the next-PC value driven to the PC register data input.
REQ-007 pc_en  output  1  SHALL be the PC register load enable.
REQ-008 imem_req_valid / imem_req_ready  output / input  1 / 1  SHALL be the fetch-request handshake.
REQ-009 imem_req_addr  output  64  SHALL equal pc_q.
REQ-010 imem_rsp_valid / imem_rsp_err  input / input  1 / 1  SHALL be response-present and access-fault flags.
REQ-011 imem_rsp_data  input  32  SHALL be the fetched instruction word.
REQ-012 inst_valid / inst_ready  output / input  1 / 1  SHALL be the instruction handshake toward decode.
REQ-013 inst_data / inst_pc  output / output  32 / 64  SHALL be the presented instruction and its address.
REQ-014 redirect_valid / redirect_target  input / input  1 / 64  SHALL be a branch/jump redirect request and target.
REQ-015 trap / trap_cause  output / output  1 / 1  SHALL be a one-cycle trap pulse; cause 0 = access fault, 1 = misaligned target.

Function
REQ-016 States SHALL be BOOT, REQ, WAIT, HOLD, DRAIN; pc_en SHALL be 0 in any cycle not listed below as a load.
REQ-017 BOOT: pc_d=RESET_VECTOR, pc_en=1, next REQ; redirect_valid SHALL be ignored in BOOT.
REQ-018 REQ: imem_req_valid=1; on imem_req_ready next WAIT; otherwise remain REQ.
REQ-019 WAIT with imem_rsp_valid, !imem_rsp_err: inst_valid=1, inst_data=imem_rsp_data, inst_pc=pc_q (same-cycle, zero added latency).
REQ-020 WAIT response accepted (inst_ready=1): pc_d=pc_q+4 modulo 2^64, pc_en=1, next REQ; not accepted: latch data and pc, next HOLD.
REQ-021 HOLD: inst_valid=1 with latched values, stable until inst_ready; on inst_ready pc_d=pc_q+4, pc_en=1, next REQ.
REQ-022 WAIT with imem_rsp_valid and imem_rsp_err: inst_valid=0, trap=1, trap_cause=0, pc_d=TRAP_VECTOR, pc_en=1, next REQ.
REQ-023 redirect_valid (any state but BOOT) SHALL have priority over every other event: pc_d=redirect_target, pc_en=1, inst_valid=0, trap=0.
REQ-024 Redirect next state: REQ from REQ without ready, HOLD, or WAIT with same-cycle response (response discarded); DRAIN from REQ with ready or WAIT without response.
REQ-025 Before acceptance, imem_req_addr SHALL change to the redirect target the cycle after a redirect; imem tolerates this.
REQ-026 DRAIN: imem_req_valid=0, inst_valid=0; on imem_rsp_valid the response (including error) SHALL be dropped, next REQ; redirect in DRAIN loads PC and stays DRAIN.
REQ-027 At most one fetch SHALL be outstanding at any time.

Reset
REQ-028 reset high SHALL force state BOOT and the HOLD latches to zero, with outputs imem_req_valid=0, inst_valid=0, trap=0, pc_en=0, pc_d=RESET_VECTOR, inst_data=0, inst_pc=0.
REQ-029 reset asserted mid-fetch SHALL abandon the outstanding request; its late response SHALL be ignored because the block is in BOOT, then REQ issues fresh.

Configuration
REQ-030 With FETCH_SEQ_MISALIGN_TRAP_EN defined, a redirect with target[1:0]!=0 SHALL load TRAP_VECTOR and pulse trap with trap_cause=1, retaining REQ-024 next-state rules.
REQ-031 Without FETCH_SEQ_MISALIGN_TRAP_EN, redirect targets SHALL load with bits [1:0] forced to 0 and trap_cause SHALL never be 1.

Verification
REQ-032 Reset release, ready=1, response 1 cycle later, inst_ready=1 -> PC load 0x0, fetches 0x0, 0x4, 0x8 back-to-back.
REQ-033 Response at pc 0x8 with inst_ready=0 for 3 cycles -> inst_valid held 3+1 cycles with stable data/pc, pc_en only on accept.
REQ-034 Redirect to 0x200 while WAIT, response 2 cycles later -> DRAIN drops it; next request addr 0x200, no inst_valid for the old word.
REQ-035 imem_rsp_err at pc 0x40 -> trap=1 for one cycle, cause 0, next request addr 0x100; err with same-cycle redirect -> no trap.
REQ-036 Redirect to 0x202: with macro -> trap cause 1, next addr 0x100; without macro -> next addr 0x200.
REQ-037 pc_q=0xFFFF_FFFF_FFFF_FFFC accepted -> pc_d=0x0; reset asserted in WAIT -> BOOT, late response ignored.
